uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive-side UART driver: deserialises an asynchronous serial line into bytes.
//  Frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity, same baud as the TX driver.
//  Sits between the board RX pin and user logic; emits one-cycle done/err strobes per frame.
// PARAMETERS
//  BPS      9_600       receive baud rate
//  CLK_FRE  50_000_000  sys_clk frequency in Hz
//  Derived: BPS_CNT = CLK_FRE/BPS (clocks per bit, >= 4); HALF_CNT = BPS_CNT/2 (integer division)
// PORTS
//  sys_clk       in   1  system clock, all logic on its rising edge
//  sys_rst_n     in   1  synchronous reset, active low
//  uart_rxd      in   1  asynchronous serial input, idle high
//  uart_rx_data  out  8  last correctly received byte; valid when uart_rx_done is high, held until the next good frame
//  uart_rx_done  out  1  one-cycle pulse: good frame received, uart_rx_data updated in the same cycle
//  uart_rx_err   out  1  one-cycle pulse: stop bit sampled low (framing error); uart_rx_data unchanged
//  uart_rx_busy  out  1  high while state != IDLE
// BEHAVIOUR
//  Reset (sys_rst_n low at a clock edge): state=IDLE, counters=0, uart_rx_data=8'h00, uart_rx_done=0,
//   uart_rx_err=0, uart_rx_busy=0, sync/edge regs=1'b1 (idle line). Reset mid-frame aborts the frame with no strobe.
//  Input conditioning: 2-flop synchroniser rxd_s1->rxd_s2, plus delay reg rxd_s3.
//   fall = rxd_s3 & ~rxd_s2. All sampling uses rxd_s2.
//  clk_cnt [31:0] counts clocks within a bit; bit_cnt [3:0] counts data bits; shift reg [7:0].
//  FSM:
//   IDLE : clk_cnt=0, bit_cnt=0. fall -> START. Otherwise stay.
//   START: clk_cnt increments; at clk_cnt==HALF_CNT-1 sample rxd_s2, clear clk_cnt:
//          0 -> DATA (start bit confirmed); 1 -> IDLE (glitch rejected, no strobe).
//   DATA : clk_cnt counts 0..BPS_CNT-1; at BPS_CNT-1 (bit centre) clear clk_cnt,
//          shift <= {rxd_s2, shift[7:1]}, bit_cnt+1; after the 8th sample (bit_cnt==7) -> STOP.
//   STOP : at clk_cnt==BPS_CNT-1 (stop-bit centre) sample rxd_s2:
//          1 -> uart_rx_data<=shift, uart_rx_done=1; 0 -> uart_rx_err=1. Both cases -> IDLE.
//  Returning at stop-bit centre leaves half a bit to detect the next start edge; back-to-back frames must be received.
//  done/err are registered, high exactly one cycle, never simultaneously.
//  Latency: done rises HALF_CNT + 9*BPS_CNT + 3 (+/-1) clocks after the uart_rxd falling edge.
//  Line held low after a framing error (break): no retrigger until the line goes high and then falls again.
//  uart_rxd edges during START/DATA/STOP are ignored except at the sample points.
//  Counter widths: clk_cnt 32 bits; counts never exceed BPS_CNT-1, no wrap.
// TESTING  (bench: CLK_FRE=50_000_000, BPS=5_000_000 -> BPS_CNT=10, HALF_CNT=5)
//  1. Reset mid-frame: deassert reset 3 bit-periods into a frame -> no done/err, busy=0, data=8'h00;
//     the next frame 8'hA5 is received correctly.
//  2. Single frame 8'hA5, stop=1 -> exactly one done pulse, data=8'hA5, err never high,
//     done within 98..100 clocks of the start edge.
//  3. Back-to-back frames 8'h00, 8'hFF, 8'h55 with 1-bit stop, no idle gap -> three done pulses, data sequence matches.
//  4. Glitch: uart_rxd low for 3 clocks then high -> returns to IDLE, no done/err; busy pulses only briefly.
//  5. Framing error: byte 8'h3C with stop=0 -> one err pulse, no done, data keeps the previous value;
//     line held low 30 bit-periods -> no further strobes; then 8'h81 -> done, data=8'h81.
//  6. Baud tolerance: transmit 8'hC3 at BPS +/-3% -> done, data=8'hC3.

Source files
------------

// File: rtl/uart_rx_if.sv
// UART receive-side interface: serial line in, received byte and strobes out.
// The receiver binds to the slave modport; user logic (or a line driver
// model) binds to the master modport.
interface uart_rx_if;
  logic       uart_rxd;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       uart_rx_err;
  logic       uart_rx_busy;

  modport master (
    output uart_rxd,
    input  uart_rx_data,
    input  uart_rx_done,
    input  uart_rx_err,
    input  uart_rx_busy
  );

  modport slave (
    input  uart_rxd,
    output uart_rx_data,
    output uart_rx_done,
    output uart_rx_err,
    output uart_rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
// The serial input is synchronised, a falling edge starts a frame, the start
// bit is confirmed at its centre and every following bit is sampled at its
// centre. A good frame produces a one-cycle done strobe with the byte; a low
// stop bit produces a one-cycle err strobe and leaves the held byte alone.
// Returning to IDLE at the stop-bit centre leaves half a bit to catch the
// next start edge, so back-to-back frames are received.
module uart_rx #(
  parameter int BPS     = 9_600,
  parameter int CLK_FRE = 50_000_000
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  uart_rx_if.slave rx_if
);

  localparam int BPS_CNT  = CLK_FRE / BPS;
  localparam int HALF_CNT = BPS_CNT / 2;

  // Terminal counts of the in-bit clock counter.
  localparam logic [31:0] BIT_END  = 32'(BPS_CNT - 1);
  localparam logic [31:0] HALF_END = 32'(HALF_CNT - 1);
  localparam logic [3:0]  LAST_BIT = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Input conditioning: two synchroniser stages plus one delay stage.
  logic        rxd_s1_r;
  logic        rxd_s2_r;
  logic        rxd_s3_r;
  logic        fall_s;

  // Frame state.
  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] clk_cnt_r;
  logic [31:0] clk_cnt_nxt_s;
  logic [3:0]  bit_cnt_r;
  logic [3:0]  bit_cnt_nxt_s;
  logic [7:0]  shift_r;
  logic [7:0]  shift_nxt_s;

  // Output registers and their next values.
  logic [7:0]  data_r;
  logic [7:0]  data_nxt_s;
  logic        done_r;
  logic        done_nxt_s;
  logic        err_r;
  logic        err_nxt_s;
  logic        busy_r;

  // Falling edge on the synchronised line: previous sample high, current low.
  assign fall_s = rxd_s3_r & ~rxd_s2_r;

  // Synchronise the asynchronous serial input; reset to the idle (high) level.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rxd_s1_r <= 1'b1;
      rxd_s2_r <= 1'b1;
      rxd_s3_r <= 1'b1;
    end else begin
      rxd_s1_r <= rx_if.uart_rxd;
      rxd_s2_r <= rxd_s1_r;
      rxd_s3_r <= rxd_s2_r;
    end
  end

  // Frame state, counters and shift register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r   <= IDLE;
      clk_cnt_r <= 32'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      clk_cnt_r <= clk_cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // Next-state logic: bit timing, centre sampling and strobe generation.
  always_comb begin
    state_nxt_s   = state_r;
    clk_cnt_nxt_s = clk_cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    data_nxt_s    = data_r;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;

    case (state_r)
      IDLE: begin
        clk_cnt_nxt_s = 32'd0;
        bit_cnt_nxt_s = 4'd0;
        if (fall_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      START: begin
        // Half a bit after the edge: a still-low line confirms the start bit,
        // a high line means the edge was a glitch.
        if (clk_cnt_r == HALF_END) begin
          clk_cnt_nxt_s = 32'd0;
          if (!rxd_s2_r) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 32'd1;
        end
      end

      DATA: begin
        if (clk_cnt_r == BIT_END) begin
          clk_cnt_nxt_s = 32'd0;
          shift_nxt_s   = {rxd_s2_r, shift_r[7:1]};
          bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 32'd1;
        end
      end

      STOP: begin
        // Stop-bit centre: high accepts the byte, low flags a framing error.
        if (clk_cnt_r == BIT_END) begin
          clk_cnt_nxt_s = 32'd0;
          state_nxt_s   = IDLE;
          if (rxd_s2_r) begin
            data_nxt_s = shift_r;
            done_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 32'd1;
        end
      end

      default: begin
        state_nxt_s   = IDLE;
        clk_cnt_nxt_s = 32'd0;
        bit_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Registered outputs; busy tracks the state register exactly.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      data_r <= 8'h00;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      data_r <= data_nxt_s;
      done_r <= done_nxt_s;
      err_r  <= err_nxt_s;
      busy_r <= (state_nxt_s != IDLE);
    end
  end

  assign rx_if.uart_rx_data = data_r;
  assign rx_if.uart_rx_done = done_r;
  assign rx_if.uart_rx_err  = err_r;
  assign rx_if.uart_rx_busy = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at 50 MHz / 5 Mbaud (10 clocks per bit).
// Frames are driven on the serial line with time delays; each expected
// strobe is pushed to a queue as its frame is driven, and a monitor records
// every observed strobe so the scenario tasks can pop and compare them.
module tb_uart_rx;

  localparam int CLK_HALF = 10;
  localparam int BIT_T    = 20 * CLK_HALF;
  localparam int HALF_CNT = 5;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  uart_rx_if rx_if ();

  uart_rx #(
    .BPS     (5_000_000),
    .CLK_FRE (50_000_000)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_if     (rx_if.slave)
  );

  always #CLK_HALF sys_clk = ~sys_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard entries: {is_err, data}.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int busy_cnt = 0;

  // Monitor: record strobes on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rx_if.uart_rx_done === 1'b1) begin
        got_q.push_back({1'b0, rx_if.uart_rx_data});
        done_cnt = done_cnt + 1;
      end
      if (rx_if.uart_rx_err === 1'b1) begin
        got_q.push_back({1'b1, rx_if.uart_rx_data});
        err_cnt = err_cnt + 1;
      end
      if (rx_if.uart_rx_done === 1'b1 && rx_if.uart_rx_err === 1'b1) begin
        both_cnt = both_cnt + 1;
      end
      if (rx_if.uart_rx_busy === 1'b1) begin
        busy_cnt = busy_cnt + 1;
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bt);
    rx_if.uart_rxd = 1'b0;
    #bt;
    for (int i = 0; i < 8; i++) begin
      rx_if.uart_rxd = b[i];
      #bt;
    end
    rx_if.uart_rxd = stop_bit;
    #bt;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n      = 1'b0;
    rx_if.uart_rxd = 1'b1;
    idle_cycles(4);
    vectors++;
    if (rx_if.uart_rx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", rx_if.uart_rx_busy);
    end
    vectors++;
    if (rx_if.uart_rx_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", rx_if.uart_rx_done);
    end
    vectors++;
    if (rx_if.uart_rx_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b expected 0", rx_if.uart_rx_err);
    end
    vectors++;
    if (rx_if.uart_rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 00", rx_if.uart_rx_data);
    end
    sys_rst_n = 1'b1;
    idle_cycles(5);
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    int e0;
    logic [8:0] exp_e;
    logic [8:0] got_e;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      send_frame(8'hFF, 1'b1, BIT_T);
      begin
        #(BIT_T * 3 / 2);
        sys_rst_n = 1'b0;
        #(BIT_T * 3 / 2);
        sys_rst_n = 1'b1;
      end
    join
    rx_if.uart_rxd = 1'b1;
    idle_cycles(30);
    vectors++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      miscompares++;
      $display("FAIL midreset_strobes: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0);
    end
    vectors++;
    if (rx_if.uart_rx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_busy: got %b expected 0", rx_if.uart_rx_busy);
    end
    vectors++;
    if (rx_if.uart_rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_data: got %h expected 00", rx_if.uart_rx_data);
    end
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1, BIT_T);
    rx_if.uart_rxd = 1'b1;
    idle_cycles(20);
    while (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL midreset_sb: got no strobe expected %h", exp_e);
      end else begin
        got_e = got_q.pop_front();
        if (got_e !== exp_e) begin
          miscompares++;
          $display("FAIL midreset_sb: got %h expected %h", got_e, exp_e);
        end
      end
    end
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_extra: got %0d extra strobes expected 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_single();
    int d0;
    int e0;
    int lat;
    logic seen;
    logic [8:0] exp_e;
    logic [8:0] got_e;
    d0   = done_cnt;
    e0   = err_cnt;
    lat  = 0;
    seen = 1'b0;
    @(posedge sys_clk);
    #1;
    exp_q.push_back({1'b0, 8'hA5});
    fork
      send_frame(8'hA5, 1'b1, BIT_T);
      begin
        while (!seen && lat < 150) begin
          @(posedge sys_clk);
          lat++;
          #1;
          if (rx_if.uart_rx_done === 1'b1) seen = 1'b1;
        end
      end
    join
    rx_if.uart_rxd = 1'b1;
    idle_cycles(20);
    vectors++;
    if (!seen || lat < 98 || lat > 100) begin
      miscompares++;
      $display("FAIL single_latency: got seen=%b after %0d clocks expected 98..100", seen, lat);
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0);
    end
    vectors++;
    if (err_cnt - e0 !== 0) begin
      miscompares++;
      $display("FAIL single_err_count: got %0d expected 0", err_cnt - e0);
    end
    while (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL single_sb: got no strobe expected %h", exp_e);
      end else begin
        got_e = got_q.pop_front();
        if (got_e !== exp_e) begin
          miscompares++;
          $display("FAIL single_sb: got %h expected %h", got_e, exp_e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int d0;
    int e0;
    logic [8:0] exp_e;
    logic [8:0] got_e;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h55;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, bytes[i]});
      send_frame(bytes[i], 1'b1, BIT_T);
    end
    rx_if.uart_rxd = 1'b1;
    idle_cycles(20);
    vectors++;
    if (done_cnt - d0 !== 3 || err_cnt - e0 !== 0) begin
      miscompares++;
      $display("FAIL b2b_counts: got done=%0d err=%0d expected 3/0", done_cnt - d0, err_cnt - e0);
    end
    while (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_sb: got no strobe expected %h", exp_e);
      end else begin
        got_e = got_q.pop_front();
        if (got_e !== exp_e) begin
          miscompares++;
          $display("FAIL b2b_sb: got %h expected %h", got_e, exp_e);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int d0;
    int e0;
    int b0;
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
    @(posedge sys_clk);
    #1;
    rx_if.uart_rxd = 1'b0;
    idle_cycles(3);
    rx_if.uart_rxd = 1'b1;
    idle_cycles(30);
    vectors++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      miscompares++;
      $display("FAIL glitch_strobes: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0);
    end
    vectors++;
    if (busy_cnt - b0 < 1 || busy_cnt - b0 > HALF_CNT + 2) begin
      miscompares++;
      $display("FAIL glitch_busy_len: got %0d cycles expected 1..%0d", busy_cnt - b0, HALF_CNT + 2);
    end
    vectors++;
    if (rx_if.uart_rx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy_end: got %b expected 0", rx_if.uart_rx_busy);
    end
  endtask

  task automatic test_framing(input logic [7:0] prev);
    int d0;
    int e0;
    logic [8:0] exp_e;
    logic [8:0] got_e;
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back({1'b1, prev});
    send_frame(8'h3C, 1'b0, BIT_T);
    #(30 * BIT_T);
    vectors++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      miscompares++;
      $display("FAIL framing_counts: got done=%0d err=%0d expected 0/1", done_cnt - d0, err_cnt - e0);
    end
    vectors++;
    if (rx_if.uart_rx_data !== prev) begin
      miscompares++;
      $display("FAIL framing_data_hold: got %h expected %h", rx_if.uart_rx_data, prev);
    end
    rx_if.uart_rxd = 1'b1;
    #(2 * BIT_T);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1, BIT_T);
    rx_if.uart_rxd = 1'b1;
    idle_cycles(20);
    vectors++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 1) begin
      miscompares++;
      $display("FAIL framing_recover_counts: got done=%0d err=%0d expected 1/1", done_cnt - d0, err_cnt - e0);
    end
    while (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL framing_sb: got no strobe expected %h", exp_e);
      end else begin
        got_e = got_q.pop_front();
        if (got_e !== exp_e) begin
          miscompares++;
          $display("FAIL framing_sb: got %h expected %h", got_e, exp_e);
        end
      end
    end
  endtask

  task automatic test_baud_tolerance();
    int bts [2];
    int d0;
    logic [8:0] exp_e;
    logic [8:0] got_e;
    bts[0] = BIT_T * 97 / 100;
    bts[1] = BIT_T * 103 / 100;
    d0 = done_cnt;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 8'hC3});
      send_frame(8'hC3, 1'b1, bts[i]);
      rx_if.uart_rxd = 1'b1;
      idle_cycles(20);
    end
    vectors++;
    if (done_cnt - d0 !== 2) begin
      miscompares++;
      $display("FAIL baud_done_count: got %0d expected 2", done_cnt - d0);
    end
    while (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL baud_sb: got no strobe expected %h", exp_e);
      end else begin
        got_e = got_q.pop_front();
        if (got_e !== exp_e) begin
          miscompares++;
          $display("FAIL baud_sb: got %h expected %h", got_e, exp_e);
        end
      end
    end
  endtask

  task automatic test_exclusive_strobes();
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL strobes_exclusive: got %0d overlapping cycles expected 0", both_cnt);
    end
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_strobes: got %0d unmatched strobes expected 0", got_q.size());
    end
  endtask

  initial begin
    rx_if.uart_rxd = 1'b1;
    test_reset();
    test_reset_mid_frame();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing(8'h55);
    test_baud_tolerance();
    test_exclusive_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
